// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    FLASH       = 3'd6
  } state_t;

  localparam logic [2:0] LIGHT_R   = 3'b100;
  localparam logic [2:0] LIGHT_Y   = 3'b010;
  localparam logic [2:0] LIGHT_G   = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycle counter for the current phase: clear wins, hold freezes the count.
module phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         hold,
  output logic [W-1:0] elapsed
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      elapsed <= '0;
    end else if (clear) begin
      elapsed <= '0;
    end else if (!hold) begin
      elapsed <= elapsed + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_controller.sv
// Intersection phase sequencer: one shared phase timer, Moore light decode,
// pedestrian request latch and night flash mode.
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int unsigned T_MIN_GREEN  = 8,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_ALL_RED    = 2,
  parameter int unsigned T_SIDE_GREEN = 6,
  parameter int unsigned T_FLASH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_car,
  input  logic       ped_btn,
  input  logic       flash,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending
);

  localparam int unsigned T_MAX = max_of(max_of(max_of(T_MIN_GREEN, T_YELLOW),
                                                max_of(T_ALL_RED, T_SIDE_GREEN)), T_FLASH);
  localparam int unsigned W = $clog2(T_MAX + 1);

  localparam logic [W-1:0] E_MIN_GREEN  = W'(T_MIN_GREEN - 1);
  localparam logic [W-1:0] E_YELLOW     = W'(T_YELLOW - 1);
  localparam logic [W-1:0] E_ALL_RED    = W'(T_ALL_RED - 1);
  localparam logic [W-1:0] E_SIDE_GREEN = W'(T_SIDE_GREEN - 1);
  localparam logic [W-1:0] E_FLASH      = W'(T_FLASH - 1);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   elapsed;
  logic           clear;
  logic           hold;
  logic           entering;
  logic           blink_wrap;
  logic           walk_sel;
  logic           blink;
  logic           req;

  phase_timer #(.W(W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .hold    (hold),
    .elapsed (elapsed)
  );

  assign req = side_car | ped_pending | flash;

  always_comb begin
    state_next = state;
    hold       = 1'b0;
    case (state)
      MAIN_GREEN: begin
        // Timer saturates at the minimum so an idle main green never wraps.
        if (elapsed == E_MIN_GREEN) begin
          if (req) state_next = MAIN_YELLOW;
          else     hold       = 1'b1;
        end
      end
      MAIN_YELLOW: if (elapsed == E_YELLOW)     state_next = ALL_RED_1;
      ALL_RED_1:   if (elapsed == E_ALL_RED)    state_next = flash ? FLASH : SIDE_GREEN;
      SIDE_GREEN:  if (elapsed == E_SIDE_GREEN) state_next = SIDE_YELLOW;
      SIDE_YELLOW: if (elapsed == E_YELLOW)     state_next = ALL_RED_2;
      ALL_RED_2:   if (elapsed == E_ALL_RED)    state_next = flash ? FLASH : MAIN_GREEN;
      FLASH:       if (!flash)                  state_next = ALL_RED_2;
      default:                                  state_next = ALL_RED_2;
    endcase
  end

  assign entering   = (state_next != state);
  assign blink_wrap = (state == FLASH) && (elapsed == E_FLASH);
  assign clear      = entering | blink_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ALL_RED_2;
      ped_pending <= 1'b0;
      walk_sel    <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state <= state_next;
      // Entry into side green serves the latched request; later presses re-arm it.
      if (entering && state_next == SIDE_GREEN) begin
        walk_sel    <= ped_pending;
        ped_pending <= 1'b0;
      end else if (ped_btn) begin
        ped_pending <= 1'b1;
      end
      if (entering && state_next == FLASH) begin
        blink <= 1'b1;
      end else if (blink_wrap) begin
        blink <= ~blink;
      end
    end
  end

  always_comb begin
    main_light = LIGHT_R;
    side_light = LIGHT_R;
    case (state)
      MAIN_GREEN:  main_light = LIGHT_G;
      MAIN_YELLOW: main_light = LIGHT_Y;
      SIDE_GREEN:  side_light = LIGHT_G;
      SIDE_YELLOW: side_light = LIGHT_Y;
      FLASH: begin
        main_light = {1'b0, blink, 1'b0};
        side_light = {blink, 2'b00};
      end
      default: begin
        main_light = LIGHT_R;
        side_light = LIGHT_R;
      end
    endcase
  end

  assign walk = (state == SIDE_GREEN) && walk_sel;

endmodule
